bist_resp_demux: RTL and testbench
==================================

// Module: bist_resp_demux
// PURPOSE
//  Response-side counterpart of the BIST pattern-source selector: steers the 6-bit CUT response
//  stream into one of four per-channel capture registers.
//  On start, latches a 2-bit channel select, accepts NWORDS words via valid/ready,
//  updates the selected register, then pulses done and flags the channel complete.
//  Sits between CUT outputs and the BIST controller's pass/fail compare.
// PARAMETERS
//  W          6      data width of response words and capture registers
//  NWORDS     4      words accepted per capture run (>=1)
//  MISR_POLY  6'h03  feedback taps (x^6+x+1); used only when BIST_DEMUX_MISR_EN is defined
// PORTS
//  clk       in   1   single clock; all state on rising edge
//  rst       in   1   synchronous, active-high reset
//  start     in   1   pulse; begins a run when idle, ignored when busy
//  sel       in   2   target channel, sampled only on accepted start
//  in_valid  in   1   response word valid
//  in_data   in   W   response word
//  in_ready  out  1   block accepts in_data this cycle
//  y0..y3    out  W   channel capture registers
//  ch_valid  out  4   bit n set when channel n finished a run
//  busy      out  1   run in progress (CAPTURE or DONE)
//  done      out  1   one-cycle pulse at end of run
// BEHAVIOUR
//  - Reset: y0..y3=0, ch_valid=0, busy=0, done=0, in_ready=0, count=0, sel_q=0, state IDLE.
//  - FSM IDLE -> CAPTURE -> DONE -> IDLE.
//  - IDLE: in_ready=0. If start=1: sel_q<=sel, y[sel]<=0, ch_valid[sel]<=0, count<=0, go CAPTURE.
//  - CAPTURE: in_ready=1, busy=1. beat = in_valid & in_ready.
//    On each beat, update y[sel_q] and count<=count+1.
//    The beat with count==NWORDS-1 moves to DONE. No beat: hold everything.
//  - DONE, one cycle: done=1, busy=1, in_ready=0, ch_valid[sel_q]<=1, then IDLE.
//    done is asserted the cycle after the final beat.
//  - in_ready and busy decode combinationally from state. done and ch_valid are registered.
//  - Non-selected channels and their ch_valid bits hold across runs.
//  - Start and in_valid in the same IDLE cycle: word is NOT accepted.
//  - Start in CAPTURE/DONE: ignored, no effect on sel_q.
//  - count width = max(1,$clog2(NWORDS)). NWORDS=1 gives one beat then DONE.
//  - rst mid-run: all state returns to reset values, including previously completed channels.
//    rst has priority over start and beats.
// CONFIGURATION
//  - BIST_DEMUX_MISR_EN undefined: on each beat y[sel_q] <= in_data. The register holds the last word.
//  - BIST_DEMUX_MISR_EN defined: y[sel_q] is a MISR seeded to 0 at start. On each beat:
//    y <= {y[W-2:0],1'b0} ^ (y[W-1] ? MISR_POLY : 0) ^ in_data.
//  - Ports and timing are identical in both builds.
// STRUCTURE
//  - bist_pkg holds the FSM state encoding (IDLE/CAPTURE/DONE), W default and MISR_POLY default.
//  - One sub-module, bist_misr_step: combinational next-signature function (W, MISR_POLY).
//    It is instantiated once on the sel_q path and only under BIST_DEMUX_MISR_EN.
// TESTING
//  1. Reset: assert rst 2 cycles -> all outputs 0, state IDLE.
//     start during rst -> no run begins.
//  2. Plain run, sel=2: feed 11,22,33,2A on consecutive cycles -> y2=2A, y0/y1/y3=0.
//     done pulses 1 cycle after the 4th beat, ch_valid=4'b0100.
//  3. Back-pressure: sel=1, in_valid toggling 1,0,1,0...
//     -> only valid cycles count; done follows the 4th valid beat.
//     start pulsed mid-run is ignored; y2 and ch_valid[2] are unchanged.
//  4. Edge cases: start+in_valid in the same IDLE cycle -> word dropped.
//     rst after 2 beats -> all regs 0, ch_valid=0.
//     Re-run on the same channel clears its ch_valid bit on start.
//  5. MISR build, sel=0: feed 3F,00,00,00 -> y0 = 3F,3D,39,31 after successive beats.
//     Final y0=31, done pulses.
//  6. NWORDS=1 build: a single beat of 15 -> DONE the next cycle, y[sel]=15 (plain build).

Source files
------------

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared FSM encoding and defaults for the BIST response demux
// Contents: state constants (IDLE/CAPTURE/DONE), default word width, default MISR taps.
package bist_pkg;

    localparam int          W_DEF         = 6;
    localparam logic [5:0]  MISR_POLY_DEF = 6'h03;

    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_CAPTURE    = 2'd1;
    localparam logic [1:0]  ST_DONE       = 2'd2;

endpackage

// File: rtl/bist_misr_step.sv
// rtl/bist_misr_step.sv - combinational next-signature step of a W-bit MISR
// Ports:
//   cur  in   W  current signature
//   din  in   W  response word folded in this step
//   nxt  out  W  next signature
module bist_misr_step #(
    parameter int         W    = 6,
    parameter logic [W-1:0] POLY = W'(6'h03)
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] din,
    output logic [W-1:0] nxt
);

    // Shift left, fold the outgoing MSB back through the taps, then mix in the word.
    always_comb begin
        nxt = {cur[W-2:0], 1'b0} ^ (cur[W-1] ? POLY : '0) ^ din;
    end

endmodule

// File: rtl/bist_resp_demux.sv
// rtl/bist_resp_demux.sv - steers a BIST response stream into one of four capture registers
// Optional feature macro: BIST_DEMUX_MISR_EN (capture registers compact words as a MISR).
// Ports:
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   begins a run when idle
//   sel       in   2   target channel, sampled on accepted start
//   in_valid  in   1   response word valid
//   in_data   in   W   response word
//   in_ready  out  1   word accepted this cycle when in_valid
//   y0..y3    out  W   channel capture registers
//   ch_valid  out  4   per-channel run-complete flags
//   busy      out  1   run in progress
//   done      out  1   one-cycle end-of-run pulse
module bist_resp_demux
    import bist_pkg::*;
#(
    parameter int           W         = W_DEF,
    parameter int           NWORDS    = 4,
    parameter logic [W-1:0] MISR_POLY = W'(MISR_POLY_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   sel,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [3:0]   ch_valid,
    output logic         busy,
    output logic         done
);

    localparam int            CW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    logic [1:0]    state;
    logic [1:0]    sel_q;
    logic [CW-1:0] count;
    logic [W-1:0]  y_q [4];
    logic [3:0]    ch_valid_q;
    logic          done_q;
    logic          beat;
    logic [W-1:0]  y_next;

    assign in_ready = (state == ST_CAPTURE);
    assign busy     = (state == ST_CAPTURE) || (state == ST_DONE);
    assign beat     = in_valid & in_ready;

`ifdef BIST_DEMUX_MISR_EN
    // Only the selected channel ever advances, so one step function on the sel_q path suffices.
    bist_misr_step #(
        .W    (W),
        .POLY (MISR_POLY)
    ) u_misr_step (
        .cur (y_q[sel_q]),
        .din (in_data),
        .nxt (y_next)
    );
`else
    logic unused_misr_poly;
    assign unused_misr_poly = ^MISR_POLY;
    assign y_next           = in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel_q      <= 2'd0;
            count      <= '0;
            ch_valid_q <= 4'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A word presented alongside start is not accepted: in_ready is low here.
                    if (start) begin
                        sel_q           <= sel;
                        y_q[sel]        <= '0;
                        ch_valid_q[sel] <= 1'b0;
                        count           <= '0;
                        state           <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (beat) begin
                        y_q[sel_q] <= y_next;
                        count      <= count + 1'b1;
                        if (count == LAST) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    ch_valid_q[sel_q] <= 1'b1;
                    state             <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign y0       = y_q[0];
    assign y1       = y_q[1];
    assign y2       = y_q[2];
    assign y3       = y_q[3];
    assign ch_valid = ch_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bist_resp_demux.sv
// tb/tb_bist_resp_demux.sv - self-checking bench for bist_resp_demux (NWORDS=4 and NWORDS=1)
module tb_bist_resp_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic [5:0] y0, y1, y2, y3;
    logic [3:0] ch_valid;
    logic       busy;
    logic       done;

    logic       s_start;
    logic [1:0] s_sel;
    logic       s_valid;
    logic [5:0] s_data;
    logic       s_ready;
    logic [5:0] s_y0, s_y1, s_y2, s_y3;
    logic [3:0] s_ch_valid;
    logic       s_busy;
    logic       s_done;

    always #5 clk = ~clk;

    bist_resp_demux #(.W(6), .NWORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .ch_valid(ch_valid), .busy(busy), .done(done)
    );

    bist_resp_demux #(.W(6), .NWORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .sel(s_sel),
        .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
        .y0(s_y0), .y1(s_y1), .y2(s_y2), .y3(s_y3),
        .ch_valid(s_ch_valid), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        logic [1:0]      sel;
        logic [3:0][5:0] w;
        bit              gaps;
        bit              drop;
        logic [5:0]      exp_final;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [5:0] y;
    } sb_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [5];
    sb_t  sbq [$];
    logic [5:0] m_y [4];
    logic [3:0] m_cv;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] cap_step(input logic [5:0] cur, input logic [5:0] d);
`ifdef BIST_DEMUX_MISR_EN
        return {cur[4:0], 1'b0} ^ (cur[5] ? 6'h03 : 6'h00) ^ d;
`else
        return d;
`endif
    endfunction

    function automatic logic [5:0] get_y(input logic [1:0] s);
        case (s)
            2'd0:    return y0;
            2'd1:    return y1;
            2'd2:    return y2;
            default: return y3;
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] s, input logic [5:0] a, input logic [5:0] b,
                                input logic [5:0] c, input logic [5:0] d, input bit g,
                                input bit dr, input logic [5:0] e_plain, input logic [5:0] e_misr);
        vec_t v;
        v.sel  = s;
        v.w[0] = a;
        v.w[1] = b;
        v.w[2] = c;
        v.w[3] = d;
        v.gaps = g;
        v.drop = dr;
`ifdef BIST_DEMUX_MISR_EN
        v.exp_final = e_misr;
        if (e_plain == 6'h3F) v.exp_final = e_misr;
`else
        v.exp_final = e_plain;
        if (e_misr == 6'h3F) v.exp_final = e_plain;
`endif
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_y0"}, 32'(y0), 32'(m_y[0]));
        chk({tag, "_y1"}, 32'(y1), 32'(m_y[1]));
        chk({tag, "_y2"}, 32'(y2), 32'(m_y[2]));
        chk({tag, "_y3"}, 32'(y3), 32'(m_y[3]));
        chk({tag, "_ch_valid"}, 32'(ch_valid), 32'(m_cv));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [5:0] run;
        sb_t        got;
        start = 1'b1;
        sel   = v.sel;
        if (v.drop) begin
            in_valid = 1'b1;
            in_data  = 6'h3C;
        end
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        m_y[v.sel]  = 6'h00;
        m_cv[v.sel] = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_start_clears"}, 32'(get_y(v.sel)), 32'd0);
        chk({tag, "_cv_after_start"}, 32'(ch_valid), 32'(m_cv));
        sbq.push_back('{sel: v.sel, y: v.exp_final});
        run = 6'h00;
        for (int k = 0; k < 4; k++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                if (k == 1) begin
                    start = 1'b1;
                    sel   = 2'd2;
                end
                step();
                start = 1'b0;
                chk({tag, "_gap_ready"}, 32'(in_ready), 32'd1);
                chk({tag, "_gap_hold"}, 32'(get_y(v.sel)), 32'(run));
            end
            in_valid = 1'b1;
            in_data  = v.w[k];
            step();
            in_valid = 1'b0;
            run        = cap_step(run, v.w[k]);
            m_y[v.sel] = run;
            chk({tag, "_beat_y"}, 32'(get_y(v.sel)), 32'(run));
            chk({tag, "_done"}, 32'(done), (k == 3) ? 32'd1 : 32'd0);
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_no_done: got %0h expected 1", tag, done);
        end else if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_sb_empty: got 0 expected 1", tag);
        end else begin
            got = sbq.pop_front();
            chk({tag, "_sb_final"}, 32'(get_y(got.sel)), 32'(got.y));
            chk({tag, "_done_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done_ready"}, 32'(in_ready), 32'd0);
        end
        step();
        m_cv[v.sel] = 1'b1;
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        sel      = 2'd2;
        in_valid = 1'b1;
        in_data  = 6'h15;
        s_start  = 1'b0;
        s_sel    = 2'd0;
        s_valid  = 1'b0;
        s_data   = 6'h00;
        for (int i = 0; i < 4; i++) m_y[i] = 6'h00;
        m_cv = 4'b0;

        vecs[0] = mk(2'd2, 6'h11, 6'h22, 6'h33, 6'h2A, 1'b0, 1'b0, 6'h2A, 6'h0F);
        vecs[1] = mk(2'd1, 6'h05, 6'h0A, 6'h14, 6'h28, 1'b1, 1'b0, 6'h28, 6'h00);
        vecs[2] = mk(2'd2, 6'h01, 6'h02, 6'h03, 6'h04, 1'b0, 1'b1, 6'h04, 6'h02);
        vecs[3] = mk(2'd3, 6'h3F, 6'h01, 6'h20, 6'h07, 1'b0, 1'b0, 6'h07, 6'h31);
        vecs[4] = mk(2'd0, 6'h3F, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 6'h00, 6'h31);

        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        check_all("rst");
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        s_start = 1'b1;
        s_sel   = 2'd3;
        step();
        s_start = 1'b0;
        chk("n1_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = 6'h15;
        step();
        s_valid = 1'b0;
        chk("n1_done", 32'(s_done), 32'd1);
        chk("n1_y3", 32'(s_y3), 32'h15);
        step();
        chk("n1_cv", 32'(s_ch_valid), 32'h8);
        chk("n1_idle", 32'(s_busy), 32'd0);

        start = 1'b1;
        sel   = 2'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 6'h07 + 6'(k);
            step();
        end
        in_valid = 1'b0;
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_y[i] = 6'h00;
        m_cv = 4'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_n1_cv", 32'(s_ch_valid), 32'd0);
        check_all("midrst");

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
